// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor
//
// Receiving end of a board-to-board heartbeat. Watches an asynchronous square
// wave from a remote toggler, measures the interval between its transitions in
// clk cycles, and reports lock, loss and out-of-tolerance conditions.
//
// Optional feature macro: HB_MONITOR_GLITCH_FILTER_EN
//   When defined, a filter stage after the synchronizer only accepts a new
//   level after FILTER_CYC identical samples, so short glitches are dropped.
//   The FILTER_CYC parameter exists only in that build.
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous, active-high
//   hb_in         in   asynchronous heartbeat input
//   clr_err       in   one-cycle pulse, clears the sticky error flags
//   alive         out  high while locked onto the heartbeat
//   toggle_pulse  out  one-cycle pulse per accepted hb_in transition
//   period        out  last measured interval in cycles (32 bits)
//   period_valid  out  one-cycle pulse when period updates
//   err_fast      out  sticky, an interval shorter than the window was seen
//   err_slow      out  sticky, an interval longer than the window or a timeout
module heartbeat_monitor #(
  parameter int unsigned FREQ_HZ       = 100000000,
  parameter int unsigned EXP_PERIOD_NS = 1000000000,
  parameter int unsigned TOL_PCT       = 10,
  parameter int unsigned LOCK_EDGES    = 2
`ifdef HB_MONITOR_GLITCH_FILTER_EN
  ,
  parameter int unsigned FILTER_CYC    = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hb_in,
  input  logic        clr_err,
  output logic        alive,
  output logic        toggle_pulse,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        err_fast,
  output logic        err_slow
);

  // Window limits are worked out in 64 bits because EXP_CYC*(100+TOL_PCT)
  // overflows 32 bits for realistic one-second heartbeats.
  localparam longint unsigned CLK_NS      = 64'(1000000000 / FREQ_HZ);
  localparam longint unsigned EXP_CYC     = 64'(EXP_PERIOD_NS) / CLK_NS;
  localparam longint unsigned MIN_CYC     = EXP_CYC * 64'(100 - TOL_PCT) / 64'd100;
  localparam longint unsigned MAX_CYC     = EXP_CYC * 64'(100 + TOL_PCT) / 64'd100;
  localparam longint unsigned TIMEOUT_CYC = 64'd2 * MAX_CYC;

  localparam logic [31:0] MIN_C     = MIN_CYC[31:0];
  localparam logic [31:0] MAX_C     = MAX_CYC[31:0];
  localparam logic [31:0] TIMEOUT_C = TIMEOUT_CYC[31:0];
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  localparam int GW = $clog2(LOCK_EDGES + 1);
  localparam logic [GW-1:0] LOCK_N   = GW'(LOCK_EDGES);
  localparam logic [GW-1:0] GOOD_ONE = GW'(1);

  typedef enum logic [1:0] {
    WAIT_FIRST,
    MEASURE,
    LOCKED
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          lvl;
  logic          lvl_prev;
  logic          edge_q;
  logic [31:0]   cnt;
  logic [GW-1:0] good;
  logic          in_window;
  logic          too_fast;

  // Two-flop synchronizer, then the previous-level register and a registered
  // edge strobe. Registering the strobe puts the outputs three cycles after
  // the first capture of a transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      lvl_prev <= 1'b0;
      edge_q   <= 1'b0;
    end else begin
      sync1    <= hb_in;
      sync2    <= sync1;
      lvl_prev <= lvl;
      edge_q   <= lvl ^ lvl_prev;
    end
  end

`ifdef HB_MONITOR_GLITCH_FILTER_EN
  localparam int FW = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;
  localparam logic [FW-1:0] FILTER_LAST = FW'(FILTER_CYC - 1);
  localparam logic [FW-1:0] FILTER_ONE  = FW'(1);

  logic          filt;
  logic [FW-1:0] run;

  // The filtered level only follows the synchronized input once it has
  // disagreed for FILTER_CYC samples in a row; any agreement restarts the
  // count, so a pulse shorter than that never becomes an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt <= 1'b0;
      run  <= '0;
    end else if (sync2 == filt) begin
      run <= '0;
    end else if (run == FILTER_LAST) begin
      filt <= sync2;
      run  <= '0;
    end else begin
      run <= run + FILTER_ONE;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  assign in_window = (cnt >= MIN_C) && (cnt <= MAX_C);
  assign too_fast  = (cnt < MIN_C);

  // Interval counter, lock FSM and all registered outputs. The counter
  // restarts at 1 on each edge so that period is the exact cycle distance
  // between consecutive edges. clr_err is applied first so that an error
  // raised in the same cycle overrides the clear. An edge takes priority over
  // a timeout landing in the same cycle. A timeout discards the reference edge
  // and the good-interval run, so lock has to be re-earned from scratch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= WAIT_FIRST;
      cnt          <= '0;
      good         <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      toggle_pulse <= 1'b0;
      alive        <= 1'b0;
      err_fast     <= 1'b0;
      err_slow     <= 1'b0;
    end else begin
      toggle_pulse <= edge_q;
      period_valid <= 1'b0;

      if (edge_q) begin
        cnt <= 32'd1;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 32'd1;
      end

      if (clr_err) begin
        err_fast <= 1'b0;
        err_slow <= 1'b0;
      end

      case (state)
        WAIT_FIRST: begin
          if (edge_q) begin
            state <= MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (edge_q) begin
            period       <= cnt;
            period_valid <= 1'b1;
            if (in_window) begin
              if (state == MEASURE) begin
                good <= good + GOOD_ONE;
                if (good + GOOD_ONE == LOCK_N) begin
                  state <= LOCKED;
                  alive <= 1'b1;
                end
              end
            end else begin
              good  <= '0;
              alive <= 1'b0;
              state <= MEASURE;
              if (too_fast) begin
                err_fast <= 1'b1;
              end else begin
                err_slow <= 1'b1;
              end
            end
          end else if (cnt == TIMEOUT_C) begin
            err_slow <= 1'b1;
            alive    <= 1'b0;
            good     <= '0;
            state    <= WAIT_FIRST;
          end
        end
        default: begin
          state <= WAIT_FIRST;
        end
      endcase
    end
  end

endmodule
